// File: rtl/inst_rom_pkg.sv
// -----------------------------------------------------------------------------
// inst_rom_pkg
// Shared definitions for the loadable instruction memory:
//   - FSM state encoding (load / run)
//   - default and no-op instruction words
//   - clog2 helper for pointer and counter widths
// -----------------------------------------------------------------------------
package inst_rom_pkg;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } rom_state_e;

    // Returned for unloaded, out-of-range or misaligned fetches.
    localparam logic [31:0] DEFAULT_WORD = 32'hffff_ffff;
    // Driven on flush and after reset.
    localparam logic [31:0] NOP_WORD     = 32'h0000_0000;

    // Number of bits needed to hold values 0..n-1 (0 for n <= 1).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rom_array.sv
// -----------------------------------------------------------------------------
// rom_array
// DEPTH x DATA_W storage, one synchronous write port and one synchronous read
// port with read enable. No reset, so it maps onto block RAM.
//
// Ports:
//   clk    in   system clock, rising edge
//   we     in   write enable
//   waddr  in   write word address
//   wdata  in   write data
//   re     in   read enable; rdata holds its value while re=0
//   raddr  in   read word address
//   rdata  out  registered read data
// -----------------------------------------------------------------------------
module rom_array #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 32,
    parameter int AW     = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/inst_rom_sync.sv
// -----------------------------------------------------------------------------
// inst_rom_sync
// Loadable instruction memory for the IF stage. A boot loader streams the
// program in over a valid/ready port; afterwards the block serves fetches
// with a registered one-cycle read, honouring IF stall and flush.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_LOAD | accepting load words, fetch inputs ignored, data = NOP
// ST_RUN  | serving fetches, load port closed, load_start reloads
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-low reset
//   load_start   in   pulse in RUN: go back to LOAD, restart at word 0
//   load_valid   in   load word present
//   load_data    in   word to store at the load pointer
//   load_last    in   final load word
//   load_ready   out  a load word is accepted this cycle
//   load_done    out  high while in RUN
//   addr         in   fetch byte address (PC)
//   fetch_en     in   1 = advance fetch, 0 = stall (outputs hold)
//   flush        in   IF flush
//   data         out  registered instruction
//   data_valid   out  data belongs to an accepted fetch
//   addr_err     out  last fetch was misaligned or out of range
//   words_loaded out  number of valid words loaded
// -----------------------------------------------------------------------------
module inst_rom_sync #(
    parameter int                 ADDR_W       = 31,
    parameter int                 DEPTH        = 256,
    parameter int                 DATA_W       = 32,
    parameter logic [DATA_W-1:0]  DEFAULT_WORD = DATA_W'(inst_rom_pkg::DEFAULT_WORD),
    parameter logic [DATA_W-1:0]  NOP_WORD     = DATA_W'(inst_rom_pkg::NOP_WORD)
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     load_start,
    input  logic                                     load_valid,
    input  logic [DATA_W-1:0]                        load_data,
    input  logic                                     load_last,
    output logic                                     load_ready,
    output logic                                     load_done,
    input  logic [ADDR_W-1:0]                        addr,
    input  logic                                     fetch_en,
    input  logic                                     flush,
    output logic [DATA_W-1:0]                        data,
    output logic                                     data_valid,
    output logic                                     addr_err,
    output logic [inst_rom_pkg::clog2(DEPTH+1)-1:0]  words_loaded
);

    import inst_rom_pkg::*;

    localparam int IDX_W = ADDR_W - 2;
    localparam int PTR_W = max2(clog2(DEPTH), 1);
    localparam int CNT_W = clog2(DEPTH + 1);
    // One spare bit so DEPTH itself is representable next to the full index.
    localparam int CMP_W = max2(IDX_W, CNT_W) + 1;

    rom_state_e         state;
    logic [PTR_W-1:0]   ptr;
    logic [CNT_W-1:0]   wl_q;
    logic [DATA_W-1:0]  hold_word;
    logic               sel_mem;
    logic [DATA_W-1:0]  rd_data;

    logic [IDX_W-1:0]   idx;
    logic [CMP_W-1:0]   idx_x;
    logic [CMP_W-1:0]   cnt_x;
    logic [CMP_W-1:0]   depth_x;
    logic               misaligned;
    logic               out_of_range;
    logic               fetch_err;
    logic               hit;
    logic               run_fetch;
    logic               rd_en;
    logic               load_accept;
    logic               last_slot;

    // The full index is compared, so high PC bits can never alias into the
    // stored range.
    assign idx          = addr[ADDR_W-1:2];
    assign idx_x        = CMP_W'(idx);
    assign cnt_x        = CMP_W'(wl_q);
    assign depth_x      = CMP_W'(DEPTH);
    assign misaligned   = |addr[1:0];
    assign out_of_range = (idx_x >= depth_x);
    assign fetch_err    = misaligned | out_of_range;
    assign hit          = !fetch_err && (idx_x < cnt_x);

    assign run_fetch    = (state == ST_RUN) && !load_start && !flush && fetch_en;
    // A stalled or flushed cycle leaves the RAM read register untouched.
    assign rd_en        = run_fetch && hit;
    assign load_accept  = (state == ST_LOAD) && load_valid;
    assign last_slot    = (ptr == PTR_W'(DEPTH - 1));

    rom_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (PTR_W)
    ) u_rom_array (
        .clk    (clk),
        .we     (load_accept),
        .waddr  (ptr),
        .wdata  (load_data),
        .re     (rd_en),
        .raddr  (idx[PTR_W-1:0]),
        .rdata  (rd_data)
    );

    // Memory hits come straight from the RAM output register; every other
    // outcome is a constant captured in hold_word. Both sources are flops,
    // so there is no combinational path from addr to data.
    assign data         = sel_mem ? rd_data : hold_word;
    assign words_loaded = wl_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_LOAD;
            ptr        <= '0;
            wl_q       <= '0;
            hold_word  <= NOP_WORD;
            sel_mem    <= 1'b0;
            data_valid <= 1'b0;
            addr_err   <= 1'b0;
            load_ready <= 1'b1;
            load_done  <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (load_valid) begin
                        ptr  <= ptr + PTR_W'(1);
                        wl_q <= CNT_W'(ptr) + CNT_W'(1);
                        if (load_last || last_slot) begin
                            state      <= ST_RUN;
                            load_ready <= 1'b0;
                            load_done  <= 1'b1;
                        end
                    end
                end

                ST_RUN: begin
                    if (load_start) begin
                        // Outputs match a flush; the FSM reopens the loader.
                        state      <= ST_LOAD;
                        ptr        <= '0;
                        wl_q       <= '0;
                        hold_word  <= NOP_WORD;
                        sel_mem    <= 1'b0;
                        data_valid <= 1'b0;
                        addr_err   <= 1'b0;
                        load_ready <= 1'b1;
                        load_done  <= 1'b0;
                    end else if (flush) begin
                        hold_word  <= NOP_WORD;
                        sel_mem    <= 1'b0;
                        data_valid <= 1'b0;
                        addr_err   <= 1'b0;
                    end else if (fetch_en) begin
                        data_valid <= 1'b1;
                        if (fetch_err) begin
                            hold_word <= DEFAULT_WORD;
                            sel_mem   <= 1'b0;
                            addr_err  <= 1'b1;
                        end else if (hit) begin
                            sel_mem   <= 1'b1;
                            addr_err  <= 1'b0;
                        end else begin
                            hold_word <= DEFAULT_WORD;
                            sel_mem   <= 1'b0;
                            addr_err  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state      <= ST_LOAD;
                    load_ready <= 1'b1;
                    load_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_rom_sync.sv
module tb_inst_rom_sync;

    localparam int ADDR_W = 31;
    localparam int DEPTH  = 256;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 9;
    localparam logic [31:0] DEF = 32'hffff_ffff;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_start;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic              load_done;
    logic [ADDR_W-1:0] addr;
    logic              fetch_en;
    logic              flush;
    logic [DATA_W-1:0] data;
    logic              data_valid;
    logic              addr_err;
    logic [CNT_W-1:0]  words_loaded;

    always #5 clk = ~clk;

    inst_rom_sync #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .load_start   (load_start),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_last    (load_last),
        .load_ready   (load_ready),
        .load_done    (load_done),
        .addr         (addr),
        .fetch_en     (fetch_en),
        .flush        (flush),
        .data         (data),
        .data_valid   (data_valid),
        .addr_err     (addr_err),
        .words_loaded (words_loaded)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: program image plus the observable outputs.
    logic [31:0] m_mem [DEPTH];
    int          m_wl;
    int          m_ptr;
    bit          m_run;
    logic [31:0] m_data;
    bit          m_valid;
    bit          m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".data"},         data,                m_data);
        chk({tag, ".data_valid"},   32'(data_valid),     32'(m_valid));
        chk({tag, ".addr_err"},     32'(addr_err),       32'(m_err));
        chk({tag, ".load_ready"},   32'(load_ready),     32'(!m_run));
        chk({tag, ".load_done"},    32'(load_done),      32'(m_run));
        chk({tag, ".words_loaded"}, 32'(words_loaded),   32'(m_wl));
    endtask

    task automatic model_reset();
        m_run   = 1'b0;
        m_ptr   = 0;
        m_wl    = 0;
        m_data  = NOP;
        m_valid = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic model_fetch(input logic [ADDR_W-1:0] a);
        longint idx;
        idx     = longint'(a) / 4;
        m_valid = 1'b1;
        if ((longint'(a) % 4) != 0 || idx >= DEPTH) begin
            m_data = DEF;
            m_err  = 1'b1;
        end else if (idx < m_wl) begin
            m_data = m_mem[idx];
            m_err  = 1'b0;
        end else begin
            m_data = DEF;
            m_err  = 1'b0;
        end
    endtask

    task automatic model_edge(input bit ls, input bit lv, input logic [31:0] ld,
                              input bit ll, input logic [ADDR_W-1:0] a,
                              input bit fe, input bit fl);
        if (m_run) begin
            if (ls) begin
                m_run = 1'b0; m_ptr = 0; m_wl = 0;
                m_data = NOP; m_valid = 1'b0; m_err = 1'b0;
            end else if (fl) begin
                m_data = NOP; m_valid = 1'b0; m_err = 1'b0;
            end else if (fe) begin
                model_fetch(a);
            end
        end else if (lv) begin
            m_mem[m_ptr] = ld;
            m_ptr = m_ptr + 1;
            m_wl  = m_ptr;
            if (ll || m_ptr == DEPTH) m_run = 1'b1;
        end
    endtask

    // Drive one cycle of inputs, clock it, update the model, check outputs.
    task automatic cycle(input string tag, input bit ls, input bit lv,
                         input logic [31:0] ld, input bit ll,
                         input logic [ADDR_W-1:0] a, input bit fe, input bit fl);
        load_start = ls;
        load_valid = lv;
        load_data  = ld;
        load_last  = ll;
        addr       = a;
        fetch_en   = fe;
        flush      = fl;
        @(posedge clk);
        model_edge(ls, lv, ld, ll, a, fe, fl);
        #1;
        chk_all(tag);
    endtask

    task automatic load_word(input logic [31:0] w, input bit last);
        cycle("load", 1'b0, 1'b1, w, last, '0, 1'b0, 1'b0);
    endtask

    task automatic fetch(input string tag, input logic [ADDR_W-1:0] a);
        cycle(tag, 1'b0, 1'b0, '0, 1'b0, a, 1'b1, 1'b0);
    endtask

    initial begin
        logic [ADDR_W-1:0] ra;

        load_start = 0; load_valid = 0; load_data = '0; load_last = 0;
        addr = '0; fetch_en = 0; flush = 0;
        reset = 1'b0;
        model_reset();
        #12;
        chk_all("reset");
        reset = 1'b1;

        // Small program, last word flagged.
        load_word(32'h2008_0003, 1'b0);
        load_word(32'hAE08_0008, 1'b0);
        load_word(32'h0800_0013, 1'b1);
        chk("load3_done", 32'(load_done), 32'd1);

        // Fetch inputs ignored while idle in RUN with fetch_en=0
        cycle("idle", 1'b0, 1'b0, '0, 1'b0, 31'h0, 1'b0, 1'b0);

        fetch("f0", 31'h0);
        chk("f0_word", data, 32'h2008_0003);
        fetch("f4", 31'h4);
        fetch("f8", 31'h8);
        chk("f8_word", data, 32'h0800_0013);
        fetch("fC_unloaded", 31'hC);
        chk("fC_word", data, DEF);
        fetch("f400_range", 31'h400);
        chk("f400_err", 32'(addr_err), 32'd1);
        fetch("f6_misalign", 31'h6);
        chk("f6_err", 32'(addr_err), 32'd1);

        // Stall: outputs hold while addr moves.
        fetch("stall_pre", 31'h4);
        for (int i = 0; i < 3; i++) begin
            cycle("stall", 1'b0, 1'b0, '0, 1'b0, 31'h8, 1'b0, 1'b0);
            chk("stall_data", data, 32'hAE08_0008);
        end
        cycle("flush", 1'b0, 1'b0, '0, 1'b0, 31'h8, 1'b1, 1'b1);
        chk("flush_data", data, NOP);

        // Full reload without load_last.
        cycle("reload_start", 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            load_word($urandom, 1'b0);
        end
        chk("full_wl", 32'(words_loaded), 32'd256);
        cycle("extra_valid", 1'b0, 1'b1, 32'h1234_5678, 1'b1, '0, 1'b0, 1'b0);
        chk("extra_ready", 32'(load_ready), 32'd0);
        fetch("f_last", 31'h3FC);
        fetch("f_alias", 31'h1000_0400);
        fetch("f_alias2", 31'h0000_0800);

        // Randomised run, occasional reloads and flushes.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0:       ra = ADDR_W'($urandom);
                1, 2:    ra = ADDR_W'($urandom_range(0, 4 * DEPTH + 64));
                default: ra = ADDR_W'($urandom_range(0, DEPTH + 16) * 4);
            endcase
            cycle("rand", ($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1,
                  $urandom, ($urandom_range(0, 15) == 0), ra,
                  $urandom_range(0, 3) != 0, ($urandom_range(0, 9) == 0));
        end

        // Make sure we are in RUN, then load_start together with flush.
        while (!m_run) load_word($urandom, 1'b1);
        fetch("pre_lsfl", 31'h0);
        cycle("ls_flush", 1'b1, 1'b0, '0, 1'b0, 31'h0, 1'b1, 1'b1);

        // One-word program: old contents must be invisible.
        load_word(32'h0000_0000, 1'b1);
        fetch("one_f4", 31'h4);
        chk("one_f4_word", data, DEF);
        fetch("one_f0", 31'h0);

        // Reset in the middle of a load.
        cycle("ls_again", 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        load_word(32'hDEAD_0001, 1'b0);
        load_word(32'hDEAD_0002, 1'b0);
        reset = 1'b0;
        #1;
        model_reset();
        chk_all("midload_reset");
        chk("midload_wl", 32'(words_loaded), 32'd0);
        #2;
        reset = 1'b1;
        load_word(32'hC0DE_0000, 1'b0);
        load_word(32'hC0DE_0004, 1'b1);
        fetch("rl_f0", 31'h0);
        chk("rl_f0_word", data, 32'hC0DE_0000);
        fetch("rl_f4", 31'h4);
        fetch("rl_f8", 31'h8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
